// File: rtl/retire_order_unit.sv
// -----------------------------------------------------------------------------
// retire_order_unit
//
// Program-order retirement sequencer for the two-way RV32 core. Each cycle
// the write-back retire info of both datapath ways is sampled, ordered by the
// write-back order-change flag, and 0, 1 or 2 commit records are pushed into
// a circular FIFO. Records drain one per valid/ready handshake on a serial
// commit port that feeds the trace checker and commit logger. The unit only
// observes retire info; it never touches architectural state.
//
// Parameters:
//   DEPTH  FIFO entries (power of two, >= 4)
//   CNT_W  width of the retired-record counter
//
// Ports:
//   clk                      clock, rising edge
//   rstn_i                   asynchronous active-low reset
//   pc{1,2}_i                write-back PC per way, 0 marks a bubble
//   instr/rd/regwe/regdata/memwe/memaddr/memdata{1,2}_i
//                            retire info per way
//   order_change_w_i         1: way 2 is the older instruction this cycle
//   commit_ready_i           consumer accepts the head record
//   commit_valid_o           head record valid
//   commit_*_o               head record fields (0 when the FIFO is empty)
//   stall_o                  fewer than 2 free entries
//   overflow_o               sticky: a record was dropped
//   count_o                  current occupancy
//   retired_cnt_o            total records popped (wraps)
// -----------------------------------------------------------------------------
module retire_order_unit #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
) (
  input  logic                       clk,
  input  logic                       rstn_i,
  input  logic [31:0]                pc1_i,
  input  logic [31:0]                pc2_i,
  input  logic [31:0]                instr1_i,
  input  logic [31:0]                instr2_i,
  input  logic [4:0]                 rd1_i,
  input  logic [4:0]                 rd2_i,
  input  logic                       regwe1_i,
  input  logic                       regwe2_i,
  input  logic [31:0]                regdata1_i,
  input  logic [31:0]                regdata2_i,
  input  logic                       memwe1_i,
  input  logic                       memwe2_i,
  input  logic [31:0]                memaddr1_i,
  input  logic [31:0]                memaddr2_i,
  input  logic [31:0]                memdata1_i,
  input  logic [31:0]                memdata2_i,
  input  logic                       order_change_w_i,
  input  logic                       commit_ready_i,
  output logic                       commit_valid_o,
  output logic [31:0]                commit_pc_o,
  output logic [31:0]                commit_instr_o,
  output logic [4:0]                 commit_rd_o,
  output logic                       commit_regwe_o,
  output logic [31:0]                commit_regdata_o,
  output logic                       commit_memwe_o,
  output logic [31:0]                commit_memaddr_o,
  output logic [31:0]                commit_memdata_o,
  output logic                       stall_o,
  output logic                       overflow_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [CNT_W-1:0]           retired_cnt_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic        regwe;
    logic [31:0] regdata;
    logic        memwe;
    logic [31:0] memaddr;
    logic [31:0] memdata;
  } rec_t;

  // Control state
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  // Storage (data only, never reset; validity is tracked by count_q)
  rec_t mem_q [DEPTH];

  // Lane decode
  logic       vld1, vld2;
  rec_t       lane1, lane2;
  rec_t       first_rec, second_rec;
  logic [1:0] num_req;
  logic [1:0] accepted;
  logic [CW:0] free_w;
  logic       pop;
  logic [PTR_W-1:0] wr_ptr_nxt1;
  rec_t       head;

  always_comb begin
    lane1         = '0;
    lane1.pc      = pc1_i;
    lane1.instr   = instr1_i;
    lane1.rd      = rd1_i;
    // x0 is never written, so a write enable against rd = 0 is not reported
    lane1.regwe   = regwe1_i & (rd1_i != 5'd0);
    lane1.regdata = regdata1_i;
    lane1.memwe   = memwe1_i;
    lane1.memaddr = memaddr1_i;
    lane1.memdata = memdata1_i;

    lane2         = '0;
    lane2.pc      = pc2_i;
    lane2.instr   = instr2_i;
    lane2.rd      = rd2_i;
    lane2.regwe   = regwe2_i & (rd2_i != 5'd0);
    lane2.regdata = regdata2_i;
    lane2.memwe   = memwe2_i;
    lane2.memaddr = memaddr2_i;
    lane2.memdata = memdata2_i;
  end

  assign vld1 = (pc1_i != 32'd0);
  assign vld2 = (pc2_i != 32'd0);

  // Order the valid lanes oldest first. With a single valid lane the
  // order-change flag is irrelevant and that lane always goes first.
  always_comb begin
    first_rec  = lane1;
    second_rec = lane2;
    if (vld1 && vld2 && order_change_w_i) begin
      first_rec  = lane2;
      second_rec = lane1;
    end else if (!vld1) begin
      first_rec  = lane2;
    end
  end

  assign num_req = {1'b0, vld1} + {1'b0, vld2};
  assign pop     = (count_q != '0) & commit_ready_i;

  // A same-cycle pop frees a slot for the incoming records.
  assign free_w = (CW+1)'(DEPTH) - (CW+1)'(count_q) + (CW+1)'(pop);

  // Accept oldest first up to the free space; free_w < num_req implies
  // free_w is 0 or 1, so its low bits are the accepted count.
  always_comb begin
    accepted = num_req;
    if ((CW+1)'(num_req) > free_w) begin
      accepted = free_w[1:0];
    end
  end

  assign wr_ptr_nxt1 = wr_ptr_q + PTR_W'(1);

  always_comb begin
    wr_ptr_d   = wr_ptr_q + PTR_W'(accepted);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    count_d    = count_q + CW'(accepted) - CW'(pop);
    overflow_d = overflow_q | (accepted != num_req);
    retired_d  = retired_q + CNT_W'(pop);
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      retired_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      retired_q  <= retired_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accepted != 2'd0) begin
      mem_q[wr_ptr_q] <= first_rec;
    end
    if (accepted == 2'd2) begin
      mem_q[wr_ptr_nxt1] <= second_rec;
    end
  end

  // Head read is combinational; empty FIFO shows an all-zero record.
  always_comb begin
    head = '0;
    if (count_q != '0) begin
      head = mem_q[rd_ptr_q];
    end
  end

  assign commit_valid_o   = (count_q != '0);
  assign commit_pc_o      = head.pc;
  assign commit_instr_o   = head.instr;
  assign commit_rd_o      = head.rd;
  assign commit_regwe_o   = head.regwe;
  assign commit_regdata_o = head.regdata;
  assign commit_memwe_o   = head.memwe;
  assign commit_memaddr_o = head.memaddr;
  assign commit_memdata_o = head.memdata;

  // Registered count only; a same-cycle pop is deliberately not credited.
  assign stall_o       = (count_q > CW'(DEPTH - 2));
  assign overflow_o    = overflow_q;
  assign count_o       = count_q;
  assign retired_cnt_o = retired_q;

endmodule

// File: tb/tb_retire_order_unit.sv
module tb_retire_order_unit;

  localparam int DEPTH = 8;
  localparam int CNT_W = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic        regwe;
    logic [31:0] regdata;
    logic        memwe;
    logic [31:0] memaddr;
    logic [31:0] memdata;
  } rec_t;

  logic clk = 1'b0;
  logic rstn_i;
  logic [31:0] pc1_i, pc2_i, instr1_i, instr2_i;
  logic [4:0]  rd1_i, rd2_i;
  logic        regwe1_i, regwe2_i, memwe1_i, memwe2_i;
  logic [31:0] regdata1_i, regdata2_i, memaddr1_i, memaddr2_i, memdata1_i, memdata2_i;
  logic        order_change_w_i, commit_ready_i;
  logic        commit_valid_o, commit_regwe_o, commit_memwe_o;
  logic [31:0] commit_pc_o, commit_instr_o, commit_regdata_o, commit_memaddr_o, commit_memdata_o;
  logic [4:0]  commit_rd_o;
  logic        stall_o, overflow_o;
  logic [CW-1:0]    count_o;
  logic [CNT_W-1:0] retired_cnt_o;

  always #5 clk = ~clk;

  retire_order_unit #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn_i(rstn_i),
    .pc1_i(pc1_i), .pc2_i(pc2_i), .instr1_i(instr1_i), .instr2_i(instr2_i),
    .rd1_i(rd1_i), .rd2_i(rd2_i), .regwe1_i(regwe1_i), .regwe2_i(regwe2_i),
    .regdata1_i(regdata1_i), .regdata2_i(regdata2_i),
    .memwe1_i(memwe1_i), .memwe2_i(memwe2_i),
    .memaddr1_i(memaddr1_i), .memaddr2_i(memaddr2_i),
    .memdata1_i(memdata1_i), .memdata2_i(memdata2_i),
    .order_change_w_i(order_change_w_i), .commit_ready_i(commit_ready_i),
    .commit_valid_o(commit_valid_o), .commit_pc_o(commit_pc_o),
    .commit_instr_o(commit_instr_o), .commit_rd_o(commit_rd_o),
    .commit_regwe_o(commit_regwe_o), .commit_regdata_o(commit_regdata_o),
    .commit_memwe_o(commit_memwe_o), .commit_memaddr_o(commit_memaddr_o),
    .commit_memdata_o(commit_memdata_o), .stall_o(stall_o),
    .overflow_o(overflow_o), .count_o(count_o), .retired_cnt_o(retired_cnt_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: an ordered queue of pending records plus counters.
  rec_t mq[$];
  bit   m_ovf;
  int unsigned m_ret;

  function automatic rec_t exp_head();
    rec_t r = '0;
    if (mq.size() != 0) r = mq[0];
    return r;
  endfunction

  function automatic rec_t dut_head();
    return {commit_pc_o, commit_instr_o, commit_rd_o, commit_regwe_o,
            commit_regdata_o, commit_memwe_o, commit_memaddr_o, commit_memdata_o};
  endfunction

  function automatic rec_t mk_rec(input logic [31:0] pc, input logic [31:0] instr,
                                  input logic [4:0] rd, input logic regwe,
                                  input logic [31:0] regdata, input logic memwe,
                                  input logic [31:0] memaddr, input logic [31:0] memdata);
    rec_t r;
    r.pc = pc; r.instr = instr; r.rd = rd;
    r.regwe = regwe && (rd != 0);
    r.regdata = regdata; r.memwe = memwe; r.memaddr = memaddr; r.memdata = memdata;
    return r;
  endfunction

  task automatic idle_lanes();
    pc1_i = 0; pc2_i = 0; instr1_i = 0; instr2_i = 0; rd1_i = 0; rd2_i = 0;
    regwe1_i = 0; regwe2_i = 0; regdata1_i = 0; regdata2_i = 0;
    memwe1_i = 0; memwe2_i = 0; memaddr1_i = 0; memaddr2_i = 0;
    memdata1_i = 0; memdata2_i = 0; order_change_w_i = 0;
  endtask

  task automatic rand_lane(input int w, input bit valid, input logic [31:0] pc);
    logic [31:0] p;
    p = valid ? pc : 32'd0;
    if (w == 1) begin
      pc1_i = p; instr1_i = $urandom(); rd1_i = 5'($urandom_range(0, 31));
      regwe1_i = 1'($urandom()); regdata1_i = $urandom(); memwe1_i = 1'($urandom());
      memaddr1_i = $urandom(); memdata1_i = $urandom();
    end else begin
      pc2_i = p; instr2_i = $urandom(); rd2_i = 5'($urandom_range(0, 31));
      regwe2_i = 1'($urandom()); regdata2_i = $urandom(); memwe2_i = 1'($urandom());
      memaddr2_i = $urandom(); memdata2_i = $urandom();
    end
  endtask

  // Advance one clock: update the model from the current inputs, then sample #1 later.
  task automatic tick();
    rec_t req[$];
    rec_t r1, r2;
    int free;
    bit pop;
    r1 = mk_rec(pc1_i, instr1_i, rd1_i, regwe1_i, regdata1_i, memwe1_i, memaddr1_i, memdata1_i);
    r2 = mk_rec(pc2_i, instr2_i, rd2_i, regwe2_i, regdata2_i, memwe2_i, memaddr2_i, memdata2_i);
    if (pc1_i != 0 && pc2_i != 0) begin
      if (order_change_w_i) begin req.push_back(r2); req.push_back(r1); end
      else begin req.push_back(r1); req.push_back(r2); end
    end else if (pc1_i != 0) req.push_back(r1);
    else if (pc2_i != 0) req.push_back(r2);
    pop  = (mq.size() != 0) && commit_ready_i;
    free = DEPTH - mq.size() + (pop ? 1 : 0);
    if (pop) begin void'(mq.pop_front()); m_ret++; end
    foreach (req[i]) begin
      if (free > 0) begin mq.push_back(req[i]); free--; end
      else m_ovf = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn_i = 1'b0;
    #1;
    mq.delete(); m_ovf = 0; m_ret = 0;
    @(negedge clk);
    rstn_i = 1'b1;
  endtask

  task automatic test_reset();
    idle_lanes(); commit_ready_i = 0;
    rstn_i = 1'b0;
    #1;
    mq.delete(); m_ovf = 0; m_ret = 0;
    checks++;
    if ({commit_valid_o, count_o, stall_o, overflow_o, retired_cnt_o} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: got v=%0b cnt=%0d st=%0b ov=%0b ret=%0d want all 0",
               commit_valid_o, count_o, stall_o, overflow_o, retired_cnt_o);
    end
    checks++;
    if (dut_head() !== rec_t'(0)) begin
      errors++; $display("FAIL reset_fields: got %h want 0", dut_head());
    end
    @(negedge clk); rstn_i = 1'b1;
    repeat (2) tick();
    checks++;
    if (commit_valid_o !== 1'b0 || count_o !== 0 || stall_o !== 1'b0) begin
      errors++;
      $display("FAIL idle: got v=%0b cnt=%0d st=%0b want 0 0 0", commit_valid_o, count_o, stall_o);
    end
  endtask

  task automatic test_single_lane();
    do_reset(); idle_lanes(); commit_ready_i = 1;
    rand_lane(1, 1, 32'h100);
    tick(); idle_lanes();
    checks++;
    if (commit_valid_o !== 1'b1 || commit_pc_o !== 32'h100) begin
      errors++; $display("FAIL single_w1: got v=%0b pc=%h want 1 00000100", commit_valid_o, commit_pc_o);
    end
    checks++;
    if (dut_head() !== exp_head()) begin
      errors++; $display("FAIL single_w1_fields: got %h want %h", dut_head(), exp_head());
    end
    tick();
    checks++;
    if (commit_valid_o !== 1'b0 || count_o !== 0) begin
      errors++; $display("FAIL single_w1_drain: got v=%0b cnt=%0d want 0 0", commit_valid_o, count_o);
    end
    rand_lane(2, 1, 32'h104); order_change_w_i = 1;
    tick(); idle_lanes();
    checks++;
    if (commit_valid_o !== 1'b1 || commit_pc_o !== 32'h104 || count_o !== 1) begin
      errors++;
      $display("FAIL single_w2: got v=%0b pc=%h cnt=%0d want 1 00000104 1", commit_valid_o, commit_pc_o, count_o);
    end
    tick();
    checks++;
    if (commit_valid_o !== 1'b0 || retired_cnt_o !== 2) begin
      errors++; $display("FAIL single_w2_drain: got v=%0b ret=%0d want 0 2", commit_valid_o, retired_cnt_o);
    end
  endtask

  task automatic test_both_lanes();
    logic [31:0] want [4] = '{32'h200, 32'h204, 32'h208, 32'h20C};
    logic [31:0] seen [4];
    int n = 0;
    do_reset(); idle_lanes(); commit_ready_i = 1;
    rand_lane(1, 1, 32'h200); rand_lane(2, 1, 32'h204); order_change_w_i = 0;
    tick(); idle_lanes();
    for (int i = 0; i < 2; i++) begin seen[n] = commit_pc_o; n++; tick(); end
    rand_lane(1, 1, 32'h20C); rand_lane(2, 1, 32'h208); order_change_w_i = 1;
    tick(); idle_lanes();
    for (int i = 0; i < 2; i++) begin seen[n] = commit_pc_o; n++; tick(); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (seen[i] !== want[i]) begin
        errors++; $display("FAIL order_%0d: got pc=%h want %h", i, seen[i], want[i]);
      end
    end
    checks++;
    if (retired_cnt_o !== 4 || commit_valid_o !== 1'b0) begin
      errors++; $display("FAIL order_retired: got ret=%0d v=%0b want 4 0", retired_cnt_o, commit_valid_o);
    end
  endtask

  task automatic test_rd_zero();
    do_reset(); idle_lanes(); commit_ready_i = 0;
    pc1_i = 32'h300; rd1_i = 5'd0; regwe1_i = 1'b1; regdata1_i = 32'hDEAD;
    tick(); idle_lanes();
    checks++;
    if (commit_regwe_o !== 1'b0 || commit_regdata_o !== 32'hDEAD) begin
      errors++;
      $display("FAIL rd_zero: got regwe=%0b data=%h want 0 0000dead", commit_regwe_o, commit_regdata_o);
    end
    // Held stable while not ready
    tick(); tick();
    checks++;
    if (commit_pc_o !== 32'h300 || commit_regdata_o !== 32'hDEAD || count_o !== 1) begin
      errors++;
      $display("FAIL hold: got pc=%h data=%h cnt=%0d want 00000300 0000dead 1", commit_pc_o, commit_regdata_o, count_o);
    end
    commit_ready_i = 1; tick();
  endtask

  task automatic test_fill_overflow();
    logic [31:0] pc;
    do_reset(); idle_lanes(); commit_ready_i = 0;
    pc = 32'h400;
    rand_lane(1, 1, pc); pc += 4; tick();
    for (int k = 0; k < 4; k++) begin
      rand_lane(1, 1, pc); rand_lane(2, 1, pc + 4); pc += 8;
      order_change_w_i = 0;
      tick();
      checks++;
      if (count_o !== CW'(mq.size()) || stall_o !== ((DEPTH - mq.size()) < 2) || overflow_o !== m_ovf) begin
        errors++;
        $display("FAIL fill_%0d: got cnt=%0d st=%0b ov=%0b want %0d %0b %0b", k, count_o, stall_o,
                 overflow_o, mq.size(), (DEPTH - mq.size()) < 2, m_ovf);
      end
    end
    idle_lanes();
    checks++;
    if (count_o !== 8 || overflow_o !== 1'b1 || stall_o !== 1'b1) begin
      errors++; $display("FAIL full: got cnt=%0d ov=%0b st=%0b want 8 1 1", count_o, overflow_o, stall_o);
    end
    commit_ready_i = 1;
    for (int k = 0; k < DEPTH; k++) begin
      checks++;
      if (commit_pc_o !== 32'h400 + 32'(4 * k) || dut_head() !== exp_head()) begin
        errors++;
        $display("FAIL drain_%0d: got pc=%h want %h", k, commit_pc_o, 32'h400 + 32'(4 * k));
      end
      tick();
    end
    checks++;
    if (commit_valid_o !== 1'b0 || overflow_o !== 1'b1 || retired_cnt_o !== 8) begin
      errors++;
      $display("FAIL drained: got v=%0b ov=%0b ret=%0d want 0 1 8", commit_valid_o, overflow_o, retired_cnt_o);
    end
  endtask

  task automatic test_full_pop_pair();
    do_reset(); idle_lanes(); commit_ready_i = 0;
    for (int k = 0; k < 4; k++) begin
      rand_lane(1, 1, 32'h500 + 32'(8 * k)); rand_lane(2, 1, 32'h504 + 32'(8 * k)); tick();
    end
    commit_ready_i = 1; order_change_w_i = 1;
    rand_lane(1, 1, 32'h604); rand_lane(2, 1, 32'h600);
    tick(); idle_lanes(); commit_ready_i = 0;
    checks++;
    if (count_o !== 8 || overflow_o !== 1'b1 || commit_pc_o !== 32'h504) begin
      errors++;
      $display("FAIL full_pop: got cnt=%0d ov=%0b pc=%h want 8 1 00000504", count_o, overflow_o, commit_pc_o);
    end
    checks++;
    if (mq[DEPTH-1].pc !== 32'h600 || dut_head() !== exp_head()) begin
      errors++; $display("FAIL full_pop_model: got head %h want %h", dut_head(), exp_head());
    end
  endtask

  task automatic test_reset_mid();
    do_reset(); idle_lanes(); commit_ready_i = 0;
    rand_lane(1, 1, 32'h700); tick();
    rand_lane(1, 1, 32'h704); rand_lane(2, 1, 32'h708); tick();
    rand_lane(1, 1, 32'h70C); rand_lane(2, 1, 32'h710); tick();
    idle_lanes();
    checks++;
    if (count_o !== 5) begin
      errors++; $display("FAIL pre_reset: got cnt=%0d want 5", count_o);
    end
    #2 rstn_i = 1'b0;
    #1;
    mq.delete(); m_ovf = 0; m_ret = 0;
    checks++;
    if (commit_valid_o !== 1'b0 || count_o !== 0 || commit_pc_o !== 0) begin
      errors++;
      $display("FAIL async_reset: got v=%0b cnt=%0d pc=%h want 0 0 0", commit_valid_o, count_o, commit_pc_o);
    end
    @(negedge clk); rstn_i = 1'b1;
    rand_lane(2, 1, 32'h800); rand_lane(1, 1, 32'h804); order_change_w_i = 1; commit_ready_i = 1;
    tick(); idle_lanes();
    checks++;
    if (commit_pc_o !== 32'h800 || count_o !== 2) begin
      errors++; $display("FAIL post_reset_0: got pc=%h cnt=%0d want 00000800 2", commit_pc_o, count_o);
    end
    tick();
    checks++;
    if (commit_pc_o !== 32'h804 || retired_cnt_o !== 1) begin
      errors++; $display("FAIL post_reset_1: got pc=%h ret=%0d want 00000804 1", commit_pc_o, retired_cnt_o);
    end
    tick();
  endtask

  task automatic test_random();
    int bad = 0;
    do_reset(); idle_lanes();
    for (int c = 0; c < 400; c++) begin
      rand_lane(1, $urandom_range(0, 3) != 0, $urandom() | 32'h1000);
      rand_lane(2, $urandom_range(0, 3) != 0, $urandom() | 32'h1000);
      order_change_w_i = 1'($urandom());
      commit_ready_i   = ($urandom_range(0, 9) < 6);
      tick();
      checks++;
      if ({commit_valid_o, count_o, stall_o, overflow_o, retired_cnt_o, dut_head()} !==
          {mq.size() != 0, CW'(mq.size()), (DEPTH - mq.size()) < 2, m_ovf, CNT_W'(m_ret), exp_head()}) begin
        errors++;
        if (bad < 10)
          $display("FAIL random_%0d: got v=%0b cnt=%0d st=%0b ov=%0b ret=%0d pc=%h want v=%0b cnt=%0d ov=%0b ret=%0d pc=%h",
                   c, commit_valid_o, count_o, stall_o, overflow_o, retired_cnt_o, commit_pc_o,
                   mq.size() != 0, mq.size(), m_ovf, m_ret, exp_head().pc);
        bad++;
      end
    end
    idle_lanes();
  endtask

  initial begin
    rstn_i = 1'b1;
    idle_lanes();
    commit_ready_i = 0;
    #2;
    test_reset();
    test_single_lane();
    test_both_lanes();
    test_rd_zero();
    test_fill_overflow();
    test_full_pop_pair();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/retire_order_unit.md
# retire_order_unit

Program-order retirement sequencer for the two-way RV32 core. Each cycle it samples the write-back retire outputs of both datapath ways and orders them using the write-back order-change flag. It pushes 0, 1 or 2 commit records into an internal FIFO and drains them one per handshake on a single serial commit port. The commit port feeds the trace checker and the debug/commit logger. The unit has no effect on architectural state; it only reads the retire info that each way produces.

## Interface
Parameters:
- DEPTH, 8: FIFO entries. Power of two, at least 4.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rstn_i  in  1  asynchronous, active-low reset.
- pc1_i, pc2_i  in  32  write-back PC of way 1 and way 2. A value of 0 marks a bubble (flushed slot).
- instr1_i, instr2_i  in  32  write-back instruction word.
- rd1_i, rd2_i  in  5  destination register.
- regwe1_i, regwe2_i  in  1  register write enable.
- regdata1_i, regdata2_i  in  32  register write data.
- memwe1_i, memwe2_i  in  1  store enable.
- memaddr1_i, memaddr2_i  in  32  store address.
- memdata1_i, memdata2_i  in  32  store data.
- order_change_w_i  in  1  1 means way 2 is the older instruction this cycle.
- commit_ready_i  in  1  consumer accepts the head record.
- commit_valid_o  out  1  head record valid.
- commit_pc_o  out  32  head record PC.
- commit_instr_o  out  32  head record instruction word.
- commit_rd_o  out  5  head record destination register.
- commit_regwe_o  out  1  head record register write enable.
- commit_regdata_o  out  32  head record register write data.
- commit_memwe_o  out  1  head record store enable.
- commit_memaddr_o  out  32  head record store address.
- commit_memdata_o  out  32  head record store data.
- stall_o  out  1  backpressure to the pipeline: fewer than 2 free entries.
- overflow_o  out  1  sticky flag: a record was dropped.
- count_o  out  $clog2(DEPTH)+1  current occupancy.
- retired_cnt_o  out  CNT_W  total records popped.

## Operation
- A lane is valid when its pc is not 0.
- A record holds pc, instr, rd, regwe, regdata, memwe, memaddr and memdata.
- regwe is forced to 0 when rd is 0; regdata is still stored unchanged.
- Push order when both lanes are valid:
  - order_change_w_i = 0: way 1 is pushed first, then way 2.
  - order_change_w_i = 1: way 2 is pushed first, then way 1.
- When only one lane is valid, that lane is pushed alone and order_change_w_i is ignored.
- Storage is a circular buffer with write pointer, read pointer and count. Pointers wrap modulo DEPTH.
- Pop occurs when commit_valid_o and commit_ready_i are both 1.
- Free space this cycle is DEPTH − count + pop.
  - Pushes are accepted oldest first up to the free space.
  - Any rejected record sets overflow_o, which stays set until reset.
  - The write pointer advances by the number of records accepted.
- count_next = count + accepted − pop.
- retired_cnt_o increments by 1 on each pop and wraps at 2^CNT_W.
- commit_valid_o = (count ≠ 0).
- Commit fields are a combinational read of the head entry. They are driven to 0 when count = 0.
- stall_o = (DEPTH − count < 2). It is combinational from the registered count and does not credit a same-cycle pop.

## Timing
- Reset values (asynchronous):
  - Pointers, count_o, overflow_o, retired_cnt_o all 0.
  - commit_valid_o 0; all commit fields 0; stall_o 0.
  - Reset asserted mid-operation discards all stored records immediately.
- Latency: a record pushed at edge N is visible on the commit port after edge N, i.e. during cycle N+1. There is no same-cycle bypass.
- Two records pushed in one cycle appear on consecutive handshakes, older first.
- Commit fields are held stable while commit_valid_o = 1 and commit_ready_i = 0.
- Throughput:
  - Sustained input of 2 records per cycle with commit_ready_i = 1 fills the FIFO by +1 per cycle.
  - stall_o rises once count reaches DEPTH − 1. The pipeline is required to hold write-back while stall_o = 1.
- Simultaneous events:
  - Full FIFO with a pop and 2 valid lanes: exactly 1 record (the older) is accepted and overflow_o sets.
  - Empty FIFO with pop requested: no effect (valid = 0).

## Test plan
- Reset, then idle. Expect commit_valid_o = 0, count_o = 0, stall_o = 0.
- Single-lane cases:
  - pc1 = 0x100, pc2 = 0, ready = 1. Next cycle expect commit_pc_o = 0x100, then valid = 0.
  - Repeat with pc1 = 0, pc2 = 0x104. Expect one record with pc = 0x104.
- Both lanes valid, pc1 = 0x200, pc2 = 0x204:
  - order_change = 0: expect 0x200 then 0x204.
  - order_change = 1 with pc1 = 0x20C, pc2 = 0x208: expect 0x208 then 0x20C.
  - retired_cnt_o = 4 at the end.
- rd = 0 with regwe = 1, regdata = 0xDEAD: expect commit_regwe_o = 0 and commit_regdata_o = 0xDEAD.
- ready = 0, DEPTH = 8, push 2 per cycle:
  - stall_o = 1 once count reaches 7.
  - One more pair with count = 7 leaves count = 8 and sets overflow_o.
  - Then ready = 1: exactly 8 records drain in order with pointer wrap, and overflow_o stays 1.
- Assert rstn_i with count = 5: expect valid = 0 and count = 0 immediately. After release, a new push is delivered in order.
